ram_dp_burst_reader: RTL and testbench



---
 rtl/ram_dp_burst_reader.sv | 110 +++++++++++
 tb/tb_ram_dp_burst_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_burst_reader.sv
// Read-side burst engine for a dual-port RAM with asynchronous read.
// Streams a run of words starting at req_addr and wraps the address modulo DEPTH.
module ram_dp_burst_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DEPTH_LOG-1:0] req_addr,
  input  logic [DEPTH_LOG:0]   req_len,
  output logic [DEPTH_LOG-1:0] ram_addr_rd,
  input  logic [WIDTH-1:0]     ram_data_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  localparam logic [DEPTH_LOG-1:0] PtrMax = DEPTH_LOG'(DEPTH - 1);
  localparam logic [DEPTH_LOG:0]   RemOne = (DEPTH_LOG + 1)'(1);

  logic [0:0]           state_q, state_d;
  logic [DEPTH_LOG-1:0] ptr_q, ptr_d;
  logic [DEPTH_LOG:0]   remaining_q, remaining_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 load;

  // A new word may enter the output stage when it is empty or being drained.
  assign load = (remaining_q != '0) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          ptr_d       = req_addr;
          remaining_d = req_len;
          if (req_len != '0) begin
            state_d = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (load) begin
          out_data_d  = ram_data_rd;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == RemOne);
          ptr_d       = (ptr_q == PtrMax) ? '0 : ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = StIdle;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign busy        = (state_q == StRead);
  assign ram_addr_rd = ptr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ram_dp_burst_reader.sv
// Directed bench for ram_dp_burst_reader with a behavioural async-read RAM.
module tb_ram_dp_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [4:0] req_len;
  logic [3:0] ram_addr_rd;
  logic [7:0] ram_data_rd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  logic       we;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;
  int hs = 0;

  ram_dp_burst_reader #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .ram_addr_rd(ram_addr_rd), .ram_data_rd(ram_data_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign ram_data_rd = mem[ram_addr_rd];
  always @(posedge clk) if (we) mem[waddr] <= wdata;
  always @(posedge clk) if (!rst && out_valid && out_ready) hs <= hs + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [3:0] a, input logic [4:0] n);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int d, input int last);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), d);
    chk({tag, "_last"}, 32'(out_last), last);
  endtask

  task automatic finish_burst(input string tag);
    tick();
    chk({tag, "_end_valid"}, 32'(out_valid), 0);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_ready"}, 32'(req_ready), 1);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 0);
  endtask

  initial begin
    int rdy [6];
    int ed [6];
    int el [6];
    int hs_base;
    rdy = '{1, 0, 0, 1, 0, 1};
    ed  = '{'h10, 'h11, 'h11, 'h11, 'h12, 'h12};
    el  = '{0, 0, 0, 0, 1, 1};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    we = 1'b1; waddr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i);
      wdata = 8'('h10 + i);
      tick();
    end
    we = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(ram_addr_rd), 0);
    rst = 1'b0;
    tick();

    // Basic burst
    request(4'd3, 5'd4);
    chk("basic_busy", 32'(busy), 1);
    chk("basic_ready", 32'(req_ready), 0);
    chk("basic_e0_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_beat("basic", 'h13 + i, (i == 3) ? 1 : 0);
    end
    finish_burst("basic");

    // Wrap-around, addresses 14,15,0,1
    request(4'd14, 5'd4);
    chk("wrap_addr0", 32'(ram_addr_rd), 14);
    tick(); expect_beat("wrap0", 'h1E, 0); chk("wrap_addr1", 32'(ram_addr_rd), 15);
    tick(); expect_beat("wrap1", 'h1F, 0); chk("wrap_addr2", 32'(ram_addr_rd), 0);
    tick(); expect_beat("wrap2", 'h10, 0); chk("wrap_addr3", 32'(ram_addr_rd), 1);
    tick(); expect_beat("wrap3", 'h11, 1);
    finish_burst("wrap");

    // Length beyond DEPTH
    request(4'd0, 5'd20);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_beat("long", 'h10 + (i % 16), (i == 19) ? 1 : 0);
    end
    finish_burst("long");

    // Backpressure
    hs_base = hs;
    request(4'd0, 5'd3);
    tick();
    for (int k = 0; k < 6; k++) begin
      out_ready = rdy[k][0];
      expect_beat("bp", ed[k], el[k]);
      tick();
    end
    chk("bp_end_valid", 32'(out_valid), 0);
    chk("bp_done", 32'(done), 1);
    chk("bp_handshakes", 32'(hs - hs_base), 3);
    out_ready = 1'b1;
    tick();
    chk("bp_done_clr", 32'(done), 0);

    // Zero length
    request(4'd7, 5'd0);
    chk("zero_ready", 32'(req_ready), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_valid", 32'(out_valid), 0);
    chk("zero_done", 32'(done), 1);
    tick();
    chk("zero_done_clr", 32'(done), 0);
    chk("zero_valid2", 32'(out_valid), 0);

    // Request held while busy
    request(4'd0, 5'd5);
    req_valid = 1'b1; req_addr = 4'd8; req_len = 5'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_busy", 32'(busy), 1);
      chk("held_ready", 32'(req_ready), 0);
      expect_beat("held", 'h10 + i, (i == 4) ? 1 : 0);
    end
    tick();
    chk("held_done", 32'(done), 1);
    chk("held_done_ready", 32'(req_ready), 1);
    chk("held_done_valid", 32'(out_valid), 0);
    tick();
    req_valid = 1'b0;
    chk("held_accept_busy", 32'(busy), 1);
    chk("held_accept_addr", 32'(ram_addr_rd), 8);
    tick(); expect_beat("held2_0", 'h18, 0);
    tick(); expect_beat("held2_1", 'h19, 1);
    finish_burst("held2");

    // Write collision and write-ahead
    request(4'd0, 5'd6);
    tick(); expect_beat("wr0", 'h10, 0);
    tick(); expect_beat("wr1", 'h11, 0);
    we = 1'b1; waddr = 4'd2; wdata = 8'hAA;
    tick(); expect_beat("wr_collide", 'h12, 0);
    waddr = 4'd5; wdata = 8'hBB;
    tick(); expect_beat("wr3", 'h13, 0);
    we = 1'b0;
    tick(); expect_beat("wr4", 'h14, 0);
    tick(); expect_beat("wr_ahead", 'hBB, 1);
    finish_burst("wr");
    we = 1'b1; waddr = 4'd2; wdata = 8'h12;
    tick();
    waddr = 4'd5; wdata = 8'h15;
    tick();
    we = 1'b0;

    // Mid-burst reset
    request(4'd0, 5'd8);
    tick(); expect_beat("mr0", 'h10, 0);
    tick(); expect_beat("mr1", 'h11, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ready", 32'(req_ready), 1);
    chk("mr_done", 32'(done), 0);
    tick();
    chk("mr_done2", 32'(done), 0);
    request(4'd0, 5'd2);
    tick(); expect_beat("mr_new0", 'h10, 0);
    tick(); expect_beat("mr_new1", 'h11, 1);
    finish_burst("mr_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
